// File: rtl/aie_compute_tile.sv
// rtl/aie_compute_tile.sv - byte-serial 8-bit accumulator PE for the mini AIE 2x2 CGRA ring
// Optional build macro AIE_TILE_SAT_EN: saturating ADD/SUB/MUL instead of modulo-256 wrap.
module aie_compute_tile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] switch_data_in,
  output logic [7:0] switch_data_out,
  input  logic [7:0] prev_pe_data_in,
  output logic [7:0] next_pe_data_out,
  input  logic [7:0] next_pe_data_in,
  output logic [7:0] prev_pe_data_out
);

  typedef enum logic {IDLE, OPERAND} state_t;

  localparam logic [3:0] OP_LOADI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_MUL = 4'h4,
                         OP_AND   = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8, OP_SHL = 4'h9,
                         OP_SHR   = 4'hA, OP_OUT = 4'hB;

  state_t     state, state_nx;
  logic [3:0] op_q, op_nx;
  logic [7:0] acc, acc_nx;
  logic [7:0] sw_q, sw_nx, np_q, np_nx, pp_q, pp_nx;
  logic [7:0] src;

  wire [3:0] op  = switch_data_in[7:4];
  wire [3:0] arg = switch_data_in[3:0];

  function automatic logic is_src_op(input logic [3:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_MUL) ||
           (o == OP_AND) || (o == OP_OR)  || (o == OP_XOR);
  endfunction

  function automatic logic [7:0] alu(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
`ifdef AIE_TILE_SAT_EN
    logic [8:0]  s;
    logic [15:0] p;
`endif
    alu = a;
    case (o)
`ifdef AIE_TILE_SAT_EN
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; alu = s[8] ? 8'hFF : s[7:0]; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; alu = s[8] ? 8'h00 : s[7:0]; end
      OP_MUL: begin p = {8'h00, a} * {8'h00, b}; alu = (|p[15:8]) ? 8'hFF : p[7:0]; end
`else
      OP_ADD: alu = a + b;
      OP_SUB: alu = a - b;
      OP_MUL: alu = a * b;
`endif
      OP_AND: alu = a & b;
      OP_OR:  alu = a | b;
      OP_XOR: alu = a ^ b;
      default: alu = a;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= 4'h0;
      acc   <= 8'h00;
      sw_q  <= 8'h00;
      np_q  <= 8'h00;
      pp_q  <= 8'h00;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      acc   <= acc_nx;
      sw_q  <= sw_nx;
      np_q  <= np_nx;
      pp_q  <= pp_nx;
    end
  end

  always_comb begin
    src = acc;
    case (arg[1:0])
      2'd1:    src = prev_pe_data_in;
      2'd2:    src = next_pe_data_in;
      default: src = acc;
    endcase
  end

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    acc_nx   = acc;
    sw_nx    = sw_q;
    np_nx    = np_q;
    pp_nx    = pp_q;
    if (state == OPERAND) begin
      acc_nx   = (op_q == OP_LOADI) ? switch_data_in : alu(op_q, acc, switch_data_in);
      state_nx = IDLE;
    end else if (op == OP_LOADI || (is_src_op(op) && arg[1:0] == 2'd0)) begin
      // operand arrives on the next switch byte
      op_nx    = op;
      state_nx = OPERAND;
    end else if (is_src_op(op)) begin
      acc_nx = alu(op, acc, src);
    end else if (op == OP_SHL) begin
      acc_nx = acc << arg[2:0];
    end else if (op == OP_SHR) begin
      acc_nx = acc >> arg[2:0];
    end else if (op == OP_OUT) begin
      if (arg[0]) sw_nx = acc;
      if (arg[1]) np_nx = acc;
      if (arg[2]) pp_nx = acc;
    end
  end

  assign switch_data_out  = sw_q;
  assign next_pe_data_out = np_q;
  assign prev_pe_data_out = pp_q;

endmodule

// File: tb/tb_aie_compute_tile.sv
// tb/tb_aie_compute_tile.sv - directed self-checking bench for aie_compute_tile
module tb_aie_compute_tile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] switch_data_in = 8'h00;
  logic [7:0] prev_pe_data_in = 8'h00;
  logic [7:0] next_pe_data_in = 8'h00;
  logic [7:0] switch_data_out, next_pe_data_out, prev_pe_data_out;
  int total = 0;
  int bad = 0;

  aie_compute_tile dut (
    .clk(clk), .rst_n(rst_n),
    .switch_data_in(switch_data_in), .switch_data_out(switch_data_out),
    .prev_pe_data_in(prev_pe_data_in), .next_pe_data_out(next_pe_data_out),
    .next_pe_data_in(next_pe_data_in), .prev_pe_data_out(prev_pe_data_out)
  );

  always #5 clk = ~clk;

`ifdef AIE_TILE_SAT_EN
  localparam logic [7:0] EXP_ADD = 8'hFF, EXP_MUL = 8'hFF, EXP_SUB = 8'h00;
`else
  localparam logic [7:0] EXP_ADD = 8'h10, EXP_MUL = 8'h20, EXP_SUB = 8'hFF;
`endif

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    switch_data_in = b;
  endtask

  // feeds a NOP; the negedge it returns on is where results are sampled
  task automatic idle();
    @(negedge clk);
    switch_data_in = 8'h00;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sw", switch_data_out, 8'h00);
    chk("rst_np", next_pe_data_out, 8'h00);
    chk("rst_pp", prev_pe_data_out, 8'h00);
    rst_n = 1'b1;

    send(8'h10); send(8'h05); send(8'hB1); idle();
    chk("loadi_out_sw", switch_data_out, 8'h05);
    chk("loadi_out_np", next_pe_data_out, 8'h00);
    chk("loadi_out_pp", prev_pe_data_out, 8'h00);

    send(8'h10); send(8'hF0); send(8'h20); send(8'h20); send(8'hB1); idle();
    chk("add_imm", switch_data_out, EXP_ADD);

    send(8'h10); send(8'h03);
    prev_pe_data_in = 8'h07;
    send(8'h21); send(8'hB6); idle();
    prev_pe_data_in = 8'h00;
    chk("add_prev_np", next_pe_data_out, 8'h0A);
    chk("add_prev_pp", prev_pe_data_out, 8'h0A);
    chk("add_prev_sw_hold", switch_data_out, EXP_ADD);

    send(8'h10); send(8'h12); send(8'h40); send(8'h10); send(8'hB1); idle();
    chk("mul_imm", switch_data_out, EXP_MUL);
    send(8'h10); send(8'h20); send(8'hA2); send(8'hB1); idle();
    chk("shr2", switch_data_out, 8'h08);

    send(8'h10); send(8'h80); send(8'h30); send(8'h81); send(8'hB1); idle();
    chk("sub_borrow", switch_data_out, EXP_SUB);
    send(8'h10); send(8'h42); send(8'h30); send(8'h00); send(8'hB2); idle();
    chk("sub_zero_operand", next_pe_data_out, 8'h42);

    // next-neighbour source, ACC source, shift left, reserved opcode
    send(8'h10); send(8'h5A);
    next_pe_data_in = 8'h0F;
    send(8'h62); send(8'h73); send(8'h91); send(8'hC1); send(8'h51); send(8'hB1); idle();
    next_pe_data_in = 8'h00;
    chk("and_or_shl_rsvd", switch_data_out, 8'h14);
    send(8'h83); send(8'hB4); idle();
    chk("xor_acc", prev_pe_data_out, 8'h00);
    chk("xor_sw_hold", switch_data_out, 8'h14);

    send(8'h10); send(8'h77); send(8'hB7); idle();
    chk("out_all_pp", prev_pe_data_out, 8'h77);

    send(8'h10);
    @(negedge clk);
    switch_data_in = 8'h00;
    rst_n = 1'b0;
    #2;
    chk("async_rst_sw", switch_data_out, 8'h00);
    chk("async_rst_pp", prev_pe_data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h05); send(8'hB1); idle();
    chk("rst_discard_op", switch_data_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
